// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: memory-unit FSM encoding and the memory-mapped I/O
// register addresses used by mem_ctrl and mem_mmio_regs.
package lc3_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  function automatic logic is_mmio(input logic [15:0] addr);
    return (addr == KBSR_ADDR) || (addr == KBDR_ADDR) ||
           (addr == DSR_ADDR)  || (addr == DDR_ADDR);
  endfunction

endpackage

// File: rtl/mem_mmio_regs.sv
// Keyboard/display memory-mapped registers: address decode, read mux and the
// registered kbd_rd / dsp_data / dsp_valid outputs.
module mem_mmio_regs
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] addr,
  input  logic        r_w,
  input  logic [7:0]  wdata,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_valid,
  input  logic        dsp_ready,
  output logic        hit,
  output logic [15:0] rdata,
  output logic        kbd_rd,
  output logic [7:0]  dsp_data,
  output logic        dsp_valid
);

  logic kbdr_read;
  logic ddr_write;

  assign hit       = is_mmio(addr);
  assign kbdr_read = start && !r_w && (addr == KBDR_ADDR);
  assign ddr_write = start &&  r_w && (addr == DDR_ADDR);

  // NOTE: rdata gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    rdata = '0;
    case (addr)
      KBSR_ADDR: rdata = {kbd_valid, 15'b0};
      KBDR_ADDR: rdata = {8'h00, kbd_data};
      DSR_ADDR:  rdata = {dsp_ready, 15'b0};
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbd_rd    <= 1'b0;
      dsp_valid <= 1'b0;
      dsp_data  <= 8'h00;
    end else begin
      kbd_rd    <= kbdr_read;
      dsp_valid <= ddr_write;
      if (ddr_write) dsp_data <= wdata;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// LC-3 memory access unit: MAR/MDR registers and a req/ack memory transaction
// FSM with timeout. Define MEM_CTRL_MMIO_EN to add the keyboard/display registers.
module mem_ctrl
  import lc3_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bus,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mio_en,
  input  logic        r_w,
  output logic [15:0] mar,
  output logic [15:0] mdr,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_valid,
  output logic        kbd_rd,
  input  logic        dsp_ready,
  output logic [7:0]  dsp_data,
  output logic        dsp_valid
);

  logic [1:0]  state;
  logic [15:0] cnt;
  logic        timed_out;
  logic        start;
  logic        timeout_hit;
  logic        mmio_hit;
  logic [15:0] mmio_rdata;

  // A pending MAR/MDR load takes priority; the access starts the cycle after.
  assign start       = (state == S_IDLE) && mio_en && !ld_mar && !ld_mdr;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == 16'(TIMEOUT_CYC - 1));

  assign mem_ready = (state == S_DONE);
  assign mem_err   = (state == S_DONE) && timed_out;

`ifdef MEM_CTRL_MMIO_EN
  mem_mmio_regs u_mmio (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .addr      (mar),
    .r_w       (r_w),
    .wdata     (mdr[7:0]),
    .kbd_data  (kbd_data),
    .kbd_valid (kbd_valid),
    .dsp_ready (dsp_ready),
    .hit       (mmio_hit),
    .rdata     (mmio_rdata),
    .kbd_rd    (kbd_rd),
    .dsp_data  (dsp_data),
    .dsp_valid (dsp_valid)
  );
`else
  logic unused_mmio;

  assign mmio_hit    = 1'b0;
  assign mmio_rdata  = '0;
  assign kbd_rd      = 1'b0;
  assign dsp_data    = 8'h00;
  assign dsp_valid   = 1'b0;
  assign unused_mmio = ^{kbd_data, kbd_valid, dsp_ready};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      timed_out <= 1'b0;
      mar       <= '0;
      mdr       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ld_mar)            mar <= bus;
          if (ld_mdr && !mio_en) mdr <= bus;
          if (start) begin
            timed_out <= 1'b0;
            if (mmio_hit) begin
              state <= S_DONE;
              if (!r_w) mdr <= mmio_rdata;
            end else begin
              state     <= S_REQ;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= r_w;
              mem_addr  <= mar;
              mem_wdata <= mdr;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            state   <= S_DONE;
            mem_req <= 1'b0;
            if (!mem_we) mdr <= mem_rdata;
          end else if (timeout_hit) begin
            state     <= S_DONE;
            mem_req   <= 1'b0;
            timed_out <= 1'b1;
            if (!mem_we) mdr <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: loads, write/read handshakes, timeout, deferred
// start, ignored loads/acks, reset abort and (with MEM_CTRL_MMIO_EN) MMIO.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bus;
  logic        ld_mar, ld_mdr, mio_en, r_w;
  logic [15:0] mar, mdr;
  logic        mem_ready, mem_err, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [7:0]  kbd_data;
  logic        kbd_valid, kbd_rd, dsp_ready;
  logic [7:0]  dsp_data;
  logic        dsp_valid;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ld_mar    (ld_mar),
    .ld_mdr    (ld_mdr),
    .mio_en    (mio_en),
    .r_w       (r_w),
    .mar       (mar),
    .mdr       (mdr),
    .mem_ready (mem_ready),
    .mem_err   (mem_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .kbd_data  (kbd_data),
    .kbd_valid (kbd_valid),
    .kbd_rd    (kbd_rd),
    .dsp_ready (dsp_ready),
    .dsp_data  (dsp_data),
    .dsp_valid (dsp_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] mar_v, input logic [15:0] mdr_v);
    bus = mar_v; ld_mar = 1'b1;
    tick();
    ld_mar = 1'b0; bus = mdr_v; ld_mdr = 1'b1;
    tick();
    ld_mdr = 1'b0;
  endtask

  // Caller sets r_w/mio_en/mem_rdata; ack is raised for the cycle sampled at
  // edge E<ack_at> (0 = never). ready_at counts cycles after the start edge.
  task automatic run_access(input int ack_at, input logic [15:0] exp_addr,
                            input logic [15:0] exp_wdata, input logic exp_we,
                            output int req_cycles, output int ready_at,
                            output int ready_cnt, output int err_cnt,
                            output bit bad_req);
    req_cycles = 0; ready_at = 0; ready_cnt = 0; err_cnt = 0; bad_req = 1'b0;
    tick();
    for (int c = 1; c <= 12; c++) begin
      if (mem_req) begin
        req_cycles++;
        if (mem_addr !== exp_addr || mem_wdata !== exp_wdata || mem_we !== exp_we)
          bad_req = 1'b1;
      end
      if (mem_err) err_cnt++;
      if (mem_ready) begin
        ready_cnt++;
        if (ready_at == 0) ready_at = c;
        mio_en = 1'b0;
      end
      mem_ack = (c == ack_at);
      tick();
    end
    mio_en = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if ({mar, mdr} !== 32'h0) $display("FAIL reset_mar_mdr: got %h want 0", {mar, mdr}); else passed++;
    checks++; if ({mem_addr, mem_wdata} !== 32'h0) $display("FAIL reset_addr_wdata: got %h want 0", {mem_addr, mem_wdata}); else passed++;
    checks++; if ({mem_req, mem_we, mem_ready, mem_err} !== 4'b0) $display("FAIL reset_mem_ctl: got %b want 0000", {mem_req, mem_we, mem_ready, mem_err}); else passed++;
    checks++; if ({kbd_rd, dsp_valid, dsp_data} !== 10'h0) $display("FAIL reset_io: got %h want 0", {kbd_rd, dsp_valid, dsp_data}); else passed++;
  endtask

  task automatic test_write();
    int rc, ra, rn, en; bit bad;
    load(16'h3000, 16'h1234);
    checks++; if (mar !== 16'h3000) $display("FAIL wr_mar_load: got %h want 3000", mar); else passed++;
    checks++; if (mdr !== 16'h1234) $display("FAIL wr_mdr_load: got %h want 1234", mdr); else passed++;
    r_w = 1'b1; mio_en = 1'b1;
    run_access(3, 16'h3000, 16'h1234, 1'b1, rc, ra, rn, en, bad);
    checks++; if (rc !== 3) $display("FAIL wr_req_cycles: got %0d want 3", rc); else passed++;
    checks++; if (bad) $display("FAIL wr_req_fields: got unstable/wrong addr/wdata/we want 3000/1234/1"); else passed++;
    checks++; if (rn !== 1 || ra !== 4) $display("FAIL wr_ready: got cnt %0d at %0d want 1 at 4", rn, ra); else passed++;
    checks++; if (en !== 0) $display("FAIL wr_err: got %0d want 0", en); else passed++;
    checks++; if (mdr !== 16'h1234) $display("FAIL wr_mdr_kept: got %h want 1234", mdr); else passed++;
  endtask

  task automatic test_read();
    int rc, ra, rn, en; bit bad;
    r_w = 1'b0; mio_en = 1'b1; mem_rdata = 16'hBEEF;
    run_access(1, 16'h3000, 16'h1234, 1'b0, rc, ra, rn, en, bad);
    checks++; if (mdr !== 16'hBEEF) $display("FAIL rd_mdr: got %h want beef", mdr); else passed++;
    checks++; if (rn !== 1 || ra !== 2) $display("FAIL rd_ready: got cnt %0d at %0d want 1 at 2", rn, ra); else passed++;
    checks++; if (rc !== 1 || bad) $display("FAIL rd_req: got %0d cycles bad=%0b want 1 cycle ok", rc, bad); else passed++;
  endtask

  task automatic test_timeout();
    int rc, ra, rn, en; bit bad;
    r_w = 1'b0; mio_en = 1'b1; mem_rdata = 16'h7777;
    run_access(0, 16'h3000, 16'h1234, 1'b0, rc, ra, rn, en, bad);
    checks++; if (rc !== 4) $display("FAIL to_req_cycles: got %0d want 4", rc); else passed++;
    checks++; if (rn !== 1 || ra !== 5) $display("FAIL to_ready: got cnt %0d at %0d want 1 at 5", rn, ra); else passed++;
    checks++; if (en !== 1) $display("FAIL to_err: got %0d want 1", en); else passed++;
    checks++; if (mdr !== 16'h0000) $display("FAIL to_mdr: got %h want 0000", mdr); else passed++;
  endtask

  task automatic test_defer_and_ignore();
    bus = 16'h4000; ld_mar = 1'b1; mio_en = 1'b1; r_w = 1'b0;
    tick();
    checks++; if (mar !== 16'h4000 || mem_req !== 1'b0) $display("FAIL defer_load: got mar %h req %b want 4000 0", mar, mem_req); else passed++;
    ld_mar = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h4000) $display("FAIL defer_start: got req %b addr %h want 1 4000", mem_req, mem_addr); else passed++;
    ld_mdr = 1'b1; bus = 16'hFFFF; mio_en = 1'b0;
    tick();
    checks++; if (mdr !== 16'h0000 || mem_req !== 1'b1) $display("FAIL ldmdr_in_req: got mdr %h req %b want 0000 1", mdr, mem_req); else passed++;
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    tick();
    checks++; if (mdr !== 16'h5555 || mem_ready !== 1'b1) $display("FAIL defer_done: got mdr %h rdy %b want 5555 1", mdr, mem_ready); else passed++;
    mem_ack = 1'b0;
    tick();
    ld_mdr = 1'b0;
    checks++; if (mdr !== 16'h5555 || mem_ready !== 1'b0) $display("FAIL ldmdr_in_done: got mdr %h rdy %b want 5555 0", mdr, mem_ready); else passed++;
    bus = 16'hAAAA; ld_mdr = 1'b1; mio_en = 1'b1;
    tick();
    checks++; if (mdr !== 16'h5555 || mem_req !== 1'b0) $display("FAIL ldmdr_mio: got mdr %h req %b want 5555 0", mdr, mem_req); else passed++;
    ld_mdr = 1'b0; mio_en = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    tick();
    tick();
    checks++; if (mdr !== 16'h5555 || mem_ready !== 1'b0 || mem_req !== 1'b0) $display("FAIL idle_ack: got mdr %h rdy %b req %b want 5555 0 0", mdr, mem_ready, mem_req); else passed++;
    mem_ack = 1'b0;
  endtask

`ifdef MEM_CTRL_MMIO_EN
  task automatic test_mmio();
    kbd_data = 8'h41;
    load(16'hFE02, 16'h0000);
    r_w = 1'b0; mio_en = 1'b1;
    tick();
    checks++; if (mdr !== 16'h0041 || kbd_rd !== 1'b1 || mem_ready !== 1'b1 || mem_req !== 1'b0) $display("FAIL mmio_kbdr: got mdr %h rd %b rdy %b req %b want 0041 1 1 0", mdr, kbd_rd, mem_ready, mem_req); else passed++;
    mio_en = 1'b0;
    tick();
    checks++; if (kbd_rd !== 1'b0 || mem_ready !== 1'b0) $display("FAIL mmio_kbdr_end: got rd %b rdy %b want 0 0", kbd_rd, mem_ready); else passed++;
    load(16'hFE06, 16'h0058);
    r_w = 1'b1; mio_en = 1'b1;
    tick();
    checks++; if (dsp_valid !== 1'b1 || dsp_data !== 8'h58 || mem_req !== 1'b0) $display("FAIL mmio_ddr: got v %b d %h req %b want 1 58 0", dsp_valid, dsp_data, mem_req); else passed++;
    mio_en = 1'b0;
    tick();
    checks++; if (dsp_valid !== 1'b0 || dsp_data !== 8'h58) $display("FAIL mmio_ddr_end: got v %b d %h want 0 58", dsp_valid, dsp_data); else passed++;
  endtask
`endif

  task automatic test_reset_abort();
    int rdy_seen;
    load(16'h3000, 16'h2222);
    r_w = 1'b0; mio_en = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b1) $display("FAIL abort_started: got %b want 1", mem_req); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || mar !== 16'h0 || mdr !== 16'h0 || mem_addr !== 16'h0) $display("FAIL abort_async: got req %b mar %h mdr %h addr %h want 0", mem_req, mar, mdr, mem_addr); else passed++;
    mio_en = 1'b0; mem_ack = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_ready) rdy_seen++;
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_ready) rdy_seen++;
    end
    mem_ack = 1'b0;
    checks++; if (rdy_seen !== 0 || mem_req !== 1'b0) $display("FAIL abort_no_ready: got %0d ready req %b want 0 0", rdy_seen, mem_req); else passed++;
  endtask

  initial begin
    rst_n = 1'b0; bus = '0; ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0; r_w = 1'b0;
    mem_rdata = '0; mem_ack = 1'b0; kbd_data = 8'h00; kbd_valid = 1'b0; dsp_ready = 1'b0;
    #12;
    test_reset();
    @(negedge clk) rst_n = 1'b1;
    test_write();
    test_read();
    test_timeout();
    test_defer_and_ignore();
`ifdef MEM_CTRL_MMIO_EN
    test_mmio();
`endif
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
